// File: rtl/pipe_inc_pkg.sv
// ---------------------------------------------------------------
// pipe_inc_pkg: shared types and defaults for the +1 issue pipeline
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package pipe_inc_pkg;
  localparam int DW_C         = 32;
  localparam int LAT_C        = 5;
  localparam int OBUF_DEPTH_C = 8;
  localparam int CNT_W_C      = $clog2(OBUF_DEPTH_C + 1);

  typedef logic signed [DW_C-1:0] data_t;
  typedef logic [CNT_W_C-1:0]     cnt_t;
endpackage

`default_nettype wire

// File: rtl/pipe_inc_obuf.sv
// ---------------------------------------------------------------
// pipe_inc_obuf: circular result buffer with simultaneous push/pop
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module pipe_inc_obuf
  import pipe_inc_pkg::*;
#(
  parameter int DW    = DW_C,
  parameter int DEPTH = OBUF_DEPTH_C,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic signed [DW-1:0] push_data_i,
  input  logic                 pop_i,
  output logic signed [DW-1:0] head_o,
  output logic [CNT_W-1:0]     count_o,
  output logic                 full_o,
  output logic                 empty_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic signed [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
    else if (!push_i && pop_i) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
endmodule

`default_nettype wire

// File: rtl/pipe_inc_sched.sv
// ---------------------------------------------------------------
// pipe_inc_sched: ready/valid, credit-gated front end for a fixed +1 pipeline
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module pipe_inc_sched
  import pipe_inc_pkg::*;
#(
  parameter int DW         = DW_C,
  parameter int LAT        = LAT_C,
  parameter int OBUF_DEPTH = OBUF_DEPTH_C,
  parameter int CNT_W      = $clog2(OBUF_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic signed [DW-1:0] pipe_in,
  output logic                 ready_in,
  output logic signed [DW-1:0] pipe_out1,
  output logic                 valid_out,
  input  logic                 ready_out,
  output logic [CNT_W-1:0]     in_flight,
  output logic                 idle
);
  logic signed [DW-1:0] data_q [LAT];
  logic [LAT-1:0]       vld_q;
  logic [CNT_W-1:0]     in_flight_q, in_flight_d;
  logic [CNT_W-1:0]     buf_count;
  logic                 buf_full, buf_empty;
  logic                 accept, out_pop;

  assign out_pop  = valid_out & ready_out;
  // A same-cycle pop frees a slot, so a full system still sustains one per cycle.
  assign ready_in = (in_flight_q < CNT_W'(OBUF_DEPTH)) | out_pop;
  assign accept   = valid_in & ready_in;

  always_comb begin
    in_flight_d = in_flight_q;
    if (accept && !out_pop)      in_flight_d = in_flight_q + CNT_W'(1);
    else if (!accept && out_pop) in_flight_d = in_flight_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q       <= '0;
      in_flight_q <= '0;
    end else begin
      vld_q       <= {vld_q[LAT-2:0], accept};
      in_flight_q <= in_flight_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q[0] <= pipe_in + DW'(1);
    for (int i = 1; i < LAT; i++) data_q[i] <= data_q[i-1];
  end

  pipe_inc_obuf #(
    .DW    (DW),
    .DEPTH (OBUF_DEPTH),
    .CNT_W (CNT_W)
  ) u_obuf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (vld_q[LAT-1]),
    .push_data_i (data_q[LAT-1]),
    .pop_i       (out_pop),
    .head_o      (pipe_out1),
    .count_o     (buf_count),
    .full_o      (buf_full),
    .empty_o     (buf_empty)
  );

  assign valid_out = (buf_count != '0);
  assign in_flight = in_flight_q;
  assign idle      = (in_flight_q == '0);

  // Credits must make overflow and underflow unreachable.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(vld_q[LAT-1] && buf_full && !out_pop));
      assert (!(out_pop && buf_empty));
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_pipe_inc_sched.sv
// Directed bench for pipe_inc_sched: reset, latency, streaming, backpressure,
// full push/pop, arithmetic wrap and mid-flight reset.
`default_nettype none

module tb_pipe_inc_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] pipe_in;
  logic        ready_in;
  logic [31:0] pipe_out1;
  logic        valid_out;
  logic        ready_out;
  logic [3:0]  in_flight;
  logic        idle;

  int checks = 0;
  int errors = 0;

  pipe_inc_sched dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .pipe_in   (pipe_in),
    .ready_in  (ready_in),
    .pipe_out1 (pipe_out1),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .in_flight (in_flight),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b0; pipe_in = '0; ready_out = 1'b0;
    #2;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset valid_out got %0b want 0", valid_out); end
    checks++; if (pipe_out1 !== 32'd0) begin errors++; $display("FAIL reset pipe_out1 got %0h want 0", pipe_out1); end
    checks++; if (in_flight !== 4'd0) begin errors++; $display("FAIL reset in_flight got %0d want 0", in_flight); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset idle got %0b want 1", idle); end
    checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL reset ready_in got %0b want 1", ready_in); end
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_single();
    ready_out = 1'b1; valid_in = 1'b1; pipe_in = 32'd41;
    #1;
    checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL single ready_in got %0b want 1", ready_in); end
    step();
    valid_in = 1'b0;
    checks++; if (in_flight !== 4'd1 || idle !== 1'b0) begin errors++; $display("FAIL single in_flight got %0d idle %0b want 1/0", in_flight, idle); end
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL single early_valid edge+%0d got %0b want 0", k, valid_out); end
    end
    step();
    checks++; if (valid_out !== 1'b1 || pipe_out1 !== 32'd42) begin errors++; $display("FAIL single result got v=%0b %0d want v=1 42", valid_out, pipe_out1); end
    step();
    checks++; if (valid_out !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL single after got v=%0b idle=%0b want 0/1", valid_out, idle); end
  endtask

  task automatic test_stream();
    ready_out = 1'b1;
    for (int c = 0; c < 30; c++) begin
      valid_in = (c < 20);
      pipe_in  = 32'(c);
      #1;
      if (c < 20) begin
        checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL stream ready_in c=%0d got %0b want 1", c, ready_in); end
      end
      step();
      if (c >= 5 && c <= 24) begin
        checks++; if (valid_out !== 1'b1 || pipe_out1 !== 32'(c - 4)) begin errors++; $display("FAIL stream out c=%0d got v=%0b %0d want v=1 %0d", c, valid_out, pipe_out1, c - 4); end
      end else begin
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL stream idle c=%0d got v=%0b want 0", c, valid_out); end
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic test_backpressure();
    int acc = 0;
    ready_out = 1'b0;
    for (int c = 0; c < 14; c++) begin
      valid_in = 1'b1;
      pipe_in  = 32'(100 + acc);
      #1;
      checks++; if (ready_in !== (c < 8)) begin errors++; $display("FAIL bp ready_in c=%0d got %0b want %0b", c, ready_in, (c < 8)); end
      step();
      if (c < 8) acc++;
    end
    valid_in = 1'b0;
    checks++; if (in_flight !== 4'd8) begin errors++; $display("FAIL bp in_flight got %0d want 8", in_flight); end
    checks++; if (valid_out !== 1'b1 || pipe_out1 !== 32'd101) begin errors++; $display("FAIL bp head got v=%0b %0d want v=1 101", valid_out, pipe_out1); end
    ready_out = 1'b1;
    #1;
    checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL bp ready_on_pop got %0b want 1", ready_in); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (valid_out !== 1'b1 || pipe_out1 !== 32'(101 + k)) begin errors++; $display("FAIL bp drain k=%0d got v=%0b %0d want v=1 %0d", k, valid_out, pipe_out1, 101 + k); end
      step();
    end
    checks++; if (valid_out !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL bp empty got v=%0b idle=%0b want 0/1", valid_out, idle); end
  endtask

  task automatic test_full_pushpop();
    ready_out = 1'b0;
    for (int k = 0; k < 8; k++) begin
      valid_in = 1'b1; pipe_in = 32'(200 + k);
      step();
    end
    valid_in = 1'b0;
    repeat (6) step();
    checks++; if (in_flight !== 4'd8 || ready_in !== 1'b0) begin errors++; $display("FAIL full state got in_flight=%0d ready_in=%0b want 8/0", in_flight, ready_in); end
    ready_out = 1'b1;
    for (int k = 0; k < 10; k++) begin
      valid_in = 1'b1; pipe_in = 32'(208 + k);
      #1;
      checks++; if (ready_in !== 1'b1 || in_flight !== 4'd8) begin errors++; $display("FAIL full pp k=%0d got ready_in=%0b in_flight=%0d want 1/8", k, ready_in, in_flight); end
      checks++; if (valid_out !== 1'b1 || pipe_out1 !== 32'(201 + k)) begin errors++; $display("FAIL full pp out k=%0d got v=%0b %0d want v=1 %0d", k, valid_out, pipe_out1, 201 + k); end
      step();
    end
    valid_in = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++; if (valid_out !== 1'b1 || pipe_out1 !== 32'(211 + k)) begin errors++; $display("FAIL full drain k=%0d got v=%0b %0d want v=1 %0d", k, valid_out, pipe_out1, 211 + k); end
      step();
    end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL full idle got %0b want 1", idle); end
  endtask

  task automatic test_wrap();
    ready_out = 1'b1;
    valid_in = 1'b1; pipe_in = 32'h7FFF_FFFF;
    step();
    pipe_in = 32'hFFFF_FFFF;
    step();
    valid_in = 1'b0;
    repeat (3) step();
    step();
    checks++; if (valid_out !== 1'b1 || pipe_out1 !== 32'h8000_0000) begin errors++; $display("FAIL wrap max got v=%0b %0h want v=1 80000000", valid_out, pipe_out1); end
    step();
    checks++; if (valid_out !== 1'b1 || pipe_out1 !== 32'h0000_0000) begin errors++; $display("FAIL wrap neg1 got v=%0b %0h want v=1 0", valid_out, pipe_out1); end
    step();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL wrap after got v=%0b want 0", valid_out); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    ready_out = 1'b0;
    for (int k = 0; k < 5; k++) begin
      valid_in = 1'b1; pipe_in = 32'(1 + k);
      step();
    end
    valid_in = 1'b0;
    step(); step();
    checks++; if (in_flight !== 4'd5 || valid_out !== 1'b1) begin errors++; $display("FAIL rstmid pre got in_flight=%0d v=%0b want 5/1", in_flight, valid_out); end
    rst = 1'b1;
    #1;
    checks++; if (valid_out !== 1'b0 || pipe_out1 !== 32'd0) begin errors++; $display("FAIL rstmid out got v=%0b %0h want 0/0", valid_out, pipe_out1); end
    checks++; if (in_flight !== 4'd0 || idle !== 1'b1 || ready_in !== 1'b1) begin errors++; $display("FAIL rstmid state got in_flight=%0d idle=%0b ready_in=%0b want 0/1/1", in_flight, idle, ready_in); end
    step(); step();
    rst = 1'b0;
    ready_out = 1'b1;
    valid_in = 1'b1; pipe_in = 32'd7;
    step();
    valid_in = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (valid_out === 1'b1) begin
        seen++;
        checks++; if (pipe_out1 !== 32'd8 || k != 5) begin errors++; $display("FAIL rstmid result edge+%0d got %0d want 8 at edge+5", k, pipe_out1); end
      end
    end
    checks++; if (seen != 1) begin errors++; $display("FAIL rstmid count got %0d results want 1", seen); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_full_pushpop();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/pipe_inc_sched.md
Name: pipe_inc_sched

Overview:
- Issue controller for the fixed-latency 5-stage increment pipeline (pipe_out1 = pipe_in + 1, exactly 5 cycles after a valid_in sample).
- Adds a ready/valid front end, credit-based admission and an output buffer, so downstream backpressure never stalls or corrupts in-flight data.
- Sits between a producer driving valid_in/pipe_in and a consumer that may deassert ready.

Parameters:
- DW, 32, data width; matches integer pipe_in/pipe_out1.
- LAT, 5, datapath latency in cycles; fixed stage count.
- OBUF_DEPTH, 8, output buffer entries; must be >= LAT.
- CNT_W, $clog2(OBUF_DEPTH+1), width of the credit/occupancy counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_in  in  1  producer offers pipe_in this cycle.
- pipe_in  in  DW  operand, signed two's complement.
- ready_in  out  1  scheduler accepts this cycle; transfer = valid_in & ready_in.
- pipe_out1  out  DW  result = operand + 1 (mod 2^DW).
- valid_out  out  1  pipe_out1 holds a result.
- ready_out  in  1  consumer accepts; transfer = valid_out & ready_out.
- in_flight  out  CNT_W  entries in datapath plus buffer (debug/status).
- idle  out  1  in_flight == 0.

Behaviour:
- Reset (asynchronous assert, any cycle): valid shift register cleared, buffer pointers and counts = 0, ready_in = 1, valid_out = 0, pipe_out1 = 0, in_flight = 0, idle = 1. In-flight and buffered data are discarded; no result from before reset ever appears after it.
- Datapath:
  - LAT-stage register chain with a data register and a valid bit per stage. The +1 is computed in stage 1.
  - The chain always advances and never stalls.
  - A token accepted at edge N (valid_in & ready_in sampled high) reaches the buffer write port at edge N+LAT.
- Credit/admission:
  - in_flight = datapath valid bits + buffer occupancy.
  - ready_in = (in_flight < OBUF_DEPTH) | out_pop, where out_pop = valid_out & ready_out. The pop frees a slot the same cycle.
  - ready_in is combinational from registered state and ready_out. It does not depend on valid_in.
  - This guarantees the buffer never overflows.
  - in_flight next = in_flight + accept − out_pop. Simultaneous accept and pop leaves it unchanged.
- Output buffer:
  - Circular, OBUF_DEPTH entries. Write when the stage-LAT valid bit is set; read on out_pop.
  - Pointers wrap modulo OBUF_DEPTH.
  - Push and pop in the same cycle are legal, including when full or at count 1.
  - Bypass is not required: minimum accept-to-valid_out latency is LAT+1 cycles (6 by default). Registered buffer write, then head visible.
  - valid_out = (buf_count != 0). pipe_out1 = head entry, stable while valid_out & !ready_out. pipe_out1 = 0 when empty.
- Ordering: results leave in acceptance order; no drops, no duplication.
- Arithmetic: DW-bit wrap. 0x7FFFFFFF → 0x80000000; 0xFFFFFFFF → 0x00000000.
- Steady state:
  - With ready_out held high, throughput is 1 per cycle with no bubbles; ready_in stays 1.
  - With ready_out held low, exactly OBUF_DEPTH tokens are accepted, then ready_in = 0 until a pop.
- Invariant (for assertion): accept at N with value x implies the matching result reaches the buffer at N+LAT with value x+1.

Decomposition:
- Package pipe_inc_pkg:
  - data_t typedef (logic signed [DW-1:0]).
  - LAT_C and OBUF_DEPTH_C constants.
  - cnt_t typedef.
- One sub-module: pipe_inc_obuf, the circular buffer with push/pop/count/full/empty.
- Datapath chain and credit logic stay in the top module.

Test Plan:
- Single token: reset, then valid_in=1 with pipe_in=41 for one cycle, ready_out=1 → valid_out first high 6 cycles later with pipe_out1=42, held for exactly one cycle; idle returns to 1.
- Streaming: 20 back-to-back values 0..19, ready_out=1 → ready_in never drops; outputs 1..20 in order on 20 consecutive cycles.
- Backpressure fill: ready_out=0, valid_in held high with values 100.. → exactly 8 accepted (ready_in low from the 9th cycle on), in_flight=8. Raising ready_out drains 101..108 in order, and ready_in reasserts in the same cycle as the first pop.
- Simultaneous push/pop at full: buffer full, ready_out=1 and valid_in=1 continuously → in_flight holds at 8, no overflow, order preserved.
- Wrap-around arithmetic: inputs 0x7FFFFFFF and 0xFFFFFFFF → outputs 0x80000000 and 0x00000000.
- Reset mid-operation: assert rst while 3 tokens are in the datapath and 2 are buffered → outputs reset immediately (valid_out=0, in_flight=0). After release, a new token 7 produces only 8, with no stale results.
